// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux scan sequencer: FSM encoding,
// default geometry and the select-width helper.
package mux_scan_pkg;

  localparam int DEF_NUM_CH     = 16;
  localparam int DEF_SAMPLE_DLY = 1;

  // DONE is reserved so later revisions keep this encoding.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } scan_state_e;

  function automatic int sel_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/mux_scan_sequencer_next_ch_find.sv
// Priority encoder picking the next enabled channel: lowest set bit overall
// when first=1, otherwise the lowest set bit strictly above cur.
module next_ch_find #(
  parameter int NUM_CH = 16,
  parameter int SEL_W  = 4
) (
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W-1:0]  cur,
  input  logic              first,
  output logic              found,
  output logic [SEL_W-1:0]  idx
);

  // Scan from the top down so the lowest qualifying channel wins.
  always_comb begin
    found = 1'b0;
    idx   = {SEL_W{1'b0}};
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (first || (SEL_W'(i) > cur))) begin
        found = 1'b1;
        idx   = SEL_W'(i);
      end else begin
        found = found;
        idx   = idx;
      end
    end
  end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Walks mux_sel over the enabled channels, samples the mux output once per
// channel and hands the assembled snapshot downstream on valid/ready.
module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int SEL_W      = sel_w(NUM_CH),
  parameter int SAMPLE_DLY = DEF_SAMPLE_DLY
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic [SEL_W-1:0]  mux_sel,
  input  logic              mux_in,
  output logic              busy,
  output logic              snap_valid,
  input  logic              snap_ready,
  output logic [NUM_CH-1:0] snapshot
);

  localparam int                 CNT_W      = $clog2(SAMPLE_DLY + 1);
  localparam logic [CNT_W-1:0]   CNT_RELOAD = CNT_W'(SAMPLE_DLY - 1);
  localparam logic [CNT_W-1:0]   CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [NUM_CH-1:0]  MASK_ZERO  = {NUM_CH{1'b0}};

  scan_state_e       state_q, state_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [NUM_CH-1:0] shadow_q, shadow_d;
  logic [NUM_CH-1:0] snapshot_q, snapshot_d;
  logic [SEL_W-1:0]  mux_sel_q, mux_sel_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              snap_valid_q, snap_valid_d;

  logic              in_idle_s;
  logic              accept_s;
  logic              mask_nz_s;
  logic              found_s;
  logic [SEL_W-1:0]  next_idx_s;
  logic [NUM_CH-1:0] merged_s;

  assign in_idle_s = (state_q == IDLE);
  // A pending unread snapshot blocks new scans unless it is taken this cycle.
  assign accept_s  = in_idle_s && start && !(snap_valid_q && !snap_ready);
  assign mask_nz_s = (ch_mask != MASK_ZERO);

  next_ch_find #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_next_ch_find (
    .mask  (in_idle_s ? ch_mask : mask_q),
    .cur   (mux_sel_q),
    .first (in_idle_s),
    .found (found_s),
    .idx   (next_idx_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state decision.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (accept_s && mask_nz_s) ? SETTLE : IDLE;
      SETTLE:  state_d = ((cnt_q == CNT_ZERO) && !found_s) ? IDLE : SETTLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values for each FSM state.
  always_comb begin
    mask_d       = mask_q;
    shadow_d     = shadow_q;
    snapshot_d   = snapshot_q;
    mux_sel_d    = mux_sel_q;
    cnt_d        = cnt_q;
    busy_d       = busy_q;
    snap_valid_d = snap_valid_q && !snap_ready;
    merged_s     = shadow_q;
    merged_s[mux_sel_q] = mux_in;
    case (state_q)
      IDLE: begin
        if (accept_s && mask_nz_s) begin
          mask_d    = ch_mask;
          shadow_d  = MASK_ZERO;
          busy_d    = 1'b1;
          mux_sel_d = next_idx_s;
          cnt_d     = CNT_RELOAD;
        end else if (accept_s) begin
          snapshot_d   = MASK_ZERO;
          snap_valid_d = 1'b1;
        end else begin
          busy_d = 1'b0;
        end
      end
      SETTLE: begin
        if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (found_s) begin
          shadow_d  = merged_s;
          mux_sel_d = next_idx_s;
          cnt_d     = CNT_RELOAD;
        end else begin
          shadow_d     = merged_s;
          snapshot_d   = merged_s;
          snap_valid_d = 1'b1;
          busy_d       = 1'b0;
          mux_sel_d    = {SEL_W{1'b0}};
        end
      end
      default: begin
        busy_d    = 1'b0;
        mux_sel_d = {SEL_W{1'b0}};
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q       <= MASK_ZERO;
      shadow_q     <= MASK_ZERO;
      snapshot_q   <= MASK_ZERO;
      mux_sel_q    <= {SEL_W{1'b0}};
      cnt_q        <= CNT_ZERO;
      busy_q       <= 1'b0;
      snap_valid_q <= 1'b0;
    end else begin
      mask_q       <= mask_d;
      shadow_q     <= shadow_d;
      snapshot_q   <= snapshot_d;
      mux_sel_q    <= mux_sel_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      snap_valid_q <= snap_valid_d;
    end
  end

  assign mux_sel    = mux_sel_q;
  assign busy       = busy_q;
  assign snap_valid = snap_valid_q;
  assign snapshot   = snapshot_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer: one instance with a 1-cycle and one
// with a 3-cycle sample delay, mux tree modelled as pattern[mux_sel].
module tb_mux_scan_sequencer;

  logic        clk;
  logic        rst_n;

  logic        start1, ready1, busy1, valid1, mux_in1;
  logic [15:0] mask1, pattern1, snap1;
  logic [3:0]  sel1;

  logic        start3, ready3, busy3, valid3, mux_in3;
  logic [15:0] mask3, pattern3, snap3;
  logic [3:0]  sel3;

  int n_cmp;
  int n_err;

  assign mux_in1 = pattern1[sel1];
  assign mux_in3 = pattern3[sel3];

  mux_scan_sequencer #(.NUM_CH(16), .SEL_W(4), .SAMPLE_DLY(1)) u_dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start1),
    .ch_mask    (mask1),
    .mux_sel    (sel1),
    .mux_in     (mux_in1),
    .busy       (busy1),
    .snap_valid (valid1),
    .snap_ready (ready1),
    .snapshot   (snap1)
  );

  mux_scan_sequencer #(.NUM_CH(16), .SEL_W(4), .SAMPLE_DLY(3)) u_dut3 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start3),
    .ch_mask    (mask3),
    .mux_sel    (sel3),
    .mux_in     (mux_in3),
    .busy       (busy3),
    .snap_valid (valid3),
    .snap_ready (ready3),
    .snapshot   (snap3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    start1 = 1'b0; ready1 = 1'b0; mask1 = 16'h0000; pattern1 = 16'h0000;
    start3 = 1'b0; ready3 = 1'b0; mask3 = 16'h0000; pattern3 = 16'h0000;

    #3;
    check("rst_sel",   {28'h0, sel1}, 32'h0);
    check("rst_busy",  {31'h0, busy1}, 32'h0);
    check("rst_valid", {31'h0, valid1}, 32'h0);
    check("rst_snap",  {16'h0, snap1}, 32'h0);
    #9 rst_n = 1'b1;
    tick();

    // T1: full mask, 1-cycle delay, ascending walk
    start1 = 1'b1; mask1 = 16'hFFFF; pattern1 = 16'hA5C3;
    tick();
    start1 = 1'b0;
    check("t1_sel0",  {28'h0, sel1}, 32'h0);
    check("t1_busy",  {31'h0, busy1}, 32'h1);
    for (int k = 1; k < 16; k++) begin
      tick();
      check("t1_sel",   {28'h0, sel1}, k);
      check("t1_valid_lo", {31'h0, valid1}, 32'h0);
    end
    tick();
    check("t1_valid", {31'h0, valid1}, 32'h1);
    check("t1_busy_lo", {31'h0, busy1}, 32'h0);
    check("t1_snap",  {16'h0, snap1}, 32'hA5C3);
    check("t1_sel_end", {28'h0, sel1}, 32'h0);

    // T2: sparse mask 0x00F0
    ready1 = 1'b1;
    tick();
    ready1 = 1'b0;
    check("t2_valid_clr", {31'h0, valid1}, 32'h0);
    start1 = 1'b1; mask1 = 16'h00F0; pattern1 = 16'hFFFF;
    tick();
    start1 = 1'b0;
    check("t2_sel4", {28'h0, sel1}, 32'h4);
    tick(); check("t2_sel5", {28'h0, sel1}, 32'h5);
    tick(); check("t2_sel6", {28'h0, sel1}, 32'h6);
    tick(); check("t2_sel7", {28'h0, sel1}, 32'h7);
    check("t2_valid_lo", {31'h0, valid1}, 32'h0);
    tick();
    check("t2_valid", {31'h0, valid1}, 32'h1);
    check("t2_snap",  {16'h0, snap1}, 32'h00F0);

    // T3: empty mask completes on the accept edge without busy
    ready1 = 1'b1;
    tick();
    ready1 = 1'b0;
    start1 = 1'b1; mask1 = 16'h0000;
    tick();
    start1 = 1'b0;
    check("t3_valid", {31'h0, valid1}, 32'h1);
    check("t3_snap",  {16'h0, snap1}, 32'h0);
    check("t3_busy",  {31'h0, busy1}, 32'h0);

    // T4: back-pressure blocks starts; ready+start restarts and drops valid
    ready1 = 1'b1;
    tick();
    ready1 = 1'b0;
    start1 = 1'b1; mask1 = 16'h000F; pattern1 = 16'h000A;
    tick();
    start1 = 1'b0;
    tick(); tick(); tick(); tick();
    check("t4_snap_a", {16'h0, snap1}, 32'h000A);
    start1 = 1'b1; mask1 = 16'hFFFF; pattern1 = 16'hFFFF;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("t4_hold_busy",  {31'h0, busy1}, 32'h0);
      check("t4_hold_valid", {31'h0, valid1}, 32'h1);
      check("t4_hold_snap",  {16'h0, snap1}, 32'h000A);
    end
    pattern1 = 16'h5555; ready1 = 1'b1;
    tick();
    start1 = 1'b0; ready1 = 1'b0;
    check("t4_valid_drop", {31'h0, valid1}, 32'h0);
    check("t4_busy",       {31'h0, busy1}, 32'h1);
    check("t4_sel0",       {28'h0, sel1}, 32'h0);

    // T5: async reset while on channel 7
    for (int k = 0; k < 7; k++) tick();
    check("t5_sel7", {28'h0, sel1}, 32'h7);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_sel",   {28'h0, sel1}, 32'h0);
    check("t5_rst_busy",  {31'h0, busy1}, 32'h0);
    check("t5_rst_valid", {31'h0, valid1}, 32'h0);
    check("t5_rst_snap",  {16'h0, snap1}, 32'h0);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      check("t5_no_valid", {31'h0, valid1}, 32'h0);
    end
    check("t5_no_busy", {31'h0, busy1}, 32'h0);

    // T6: 3-cycle delay, bit 15 toggles while settling
    start3 = 1'b1; mask3 = 16'h8001; pattern3 = 16'h0001;
    tick();
    start3 = 1'b0;
    check("t6_sel_a0", {28'h0, sel3}, 32'h0);
    tick(); check("t6_sel_a1", {28'h0, sel3}, 32'h0);
    tick(); check("t6_sel_a2", {28'h0, sel3}, 32'h0);
    tick(); check("t6_sel_a3", {28'h0, sel3}, 32'hF);
    pattern3 = 16'h8001;
    tick(); pattern3 = 16'h0001;
    tick(); pattern3 = 16'h8001;
    check("t6_valid_lo", {31'h0, valid3}, 32'h0);
    tick();
    check("t6_valid", {31'h0, valid3}, 32'h1);
    check("t6_snap",  {16'h0, snap3}, 32'h8001);
    check("t6_busy",  {31'h0, busy3}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
